// File: rtl/x_host_pkg.sv
// Shared definitions for the x_host driver sequencer: driver opcodes,
// host request operations, FSM states and the command byte helpers.
package x_host_pkg;

    localparam logic [3:0] CMD_LOAD   = 4'h0;
    localparam logic [3:0] CMD_UNLOAD = 4'h1;
    localparam logic [3:0] CMD_SAMPLE = 4'h2;
    localparam logic [3:0] CMD_EDGE   = 4'h3;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_READ   = 2'd1,
        OP_SAMPLE = 2'd2,
        OP_EDGE   = 2'd3
    } req_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_UNLOAD,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam logic [2:0] LAST_NIBBLE = 3'd7;
    localparam logic [1:0] LAST_BYTE   = 2'd3;
    localparam logic [2:0] LAST_SETTLE = 3'd1;

    // Nibble idx of a write word, most significant nibble first.
    function automatic logic [3:0] write_nibble(input logic [31:0] word, input logic [2:0] idx);
        return word[{3'd7 - idx, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] cmd_byte(input logic [3:0] payload, input logic [3:0] opcode);
        return {payload, opcode};
    endfunction

endpackage

// File: rtl/x_host.sv
// Host-request sequencer: turns WRITE/READ/SAMPLE/EDGE requests into driver
// command bytes and assembles the driver's return bytes into a response word.
module x_host
    import x_host_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_op,
    input  logic [31:0] i_req_data,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd_data,
    input  logic        i_drv_valid,
    input  logic [7:0]  i_drv_data,
    output logic        o_drv_accept
);

    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e            state_q,      state_d;
    req_op_e           op_q,         op_d;
    logic [31:0]       data_q,       data_d;
    logic [2:0]        nib_cnt_q,    nib_cnt_d;
    logic [1:0]        byte_cnt_q,   byte_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q,    tmo_cnt_d;
    logic              req_ready_q,  req_ready_d;
    logic              rsp_valid_q,  rsp_valid_d;
    logic [31:0]       rsp_data_q,   rsp_data_d;
    logic              rsp_err_q,    rsp_err_d;
    logic              cmd_valid_q,  cmd_valid_d;
    logic [7:0]        cmd_data_q,   cmd_data_d;

    logic drv_take;

    // The driver byte is accepted in the very cycle it is offered while waiting.
    assign drv_take = (state_q == ST_WAIT) && i_drv_valid;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case
        // can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        nib_cnt_d   = nib_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cmd_valid_d = 1'b0;
        cmd_data_d  = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid && req_ready_q) begin
                    op_d        = req_op_e'(i_req_op);
                    data_d      = i_req_data;
                    nib_cnt_d   = '0;
                    byte_cnt_d  = '0;
                    req_ready_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    cmd_valid_d = 1'b1;
                    case (req_op_e'(i_req_op))
                        OP_WRITE: begin
                            state_d    = ST_LOAD;
                            cmd_data_d = cmd_byte(write_nibble(i_req_data, 3'd0), CMD_LOAD);
                        end
                        OP_READ: begin
                            state_d    = ST_UNLOAD;
                            cmd_data_d = cmd_byte(4'h0, CMD_UNLOAD);
                        end
                        OP_SAMPLE: begin
                            state_d    = ST_UNLOAD;
                            cmd_data_d = cmd_byte(4'h0, CMD_SAMPLE);
                        end
                        default: begin
                            state_d    = ST_UNLOAD;
                            cmd_data_d = cmd_byte(4'h0, CMD_EDGE);
                        end
                    endcase
                end
            end

            ST_LOAD: begin
                if (nib_cnt_q == LAST_NIBBLE) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                end else begin
                    nib_cnt_d   = nib_cnt_q + 3'd1;
                    cmd_valid_d = 1'b1;
                    cmd_data_d  = cmd_byte(write_nibble(data_q, nib_cnt_q + 3'd1), CMD_LOAD);
                end
            end

            // The byte on the wire tells which single-byte command just went out.
            ST_UNLOAD: begin
                if (cmd_data_q[3:0] == CMD_SAMPLE) begin
                    state_d   = ST_SETTLE;
                    nib_cnt_d = '0;
                end else begin
                    state_d   = ST_WAIT;
                    tmo_cnt_d = '0;
                end
            end

            // The nibble counter is idle during SAMPLE, so it times the settle gap.
            ST_SETTLE: begin
                if (nib_cnt_q == LAST_SETTLE) begin
                    state_d     = ST_UNLOAD;
                    cmd_valid_d = 1'b1;
                    cmd_data_d  = cmd_byte(4'h0, CMD_UNLOAD);
                end else begin
                    nib_cnt_d = nib_cnt_q + 3'd1;
                end
            end

            ST_WAIT: begin
                if (drv_take) begin
                    if (op_q == OP_EDGE) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = {27'b0, i_drv_data[4:0]};
                    end else begin
                        rsp_data_d = {rsp_data_q[23:0], i_drv_data};
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_d     = ST_DONE;
                            rsp_valid_d = 1'b1;
                        end else begin
                            byte_cnt_d  = byte_cnt_q + 2'd1;
                            state_d     = ST_UNLOAD;
                            cmd_valid_d = 1'b1;
                            cmd_data_d  = cmd_byte(4'h0, CMD_UNLOAD);
                        end
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Silent driver: give up on the remaining bytes.
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the _d values computed from the previous cycle's state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WRITE;
            data_q      <= '0;
            nib_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            nib_cnt_q   <= nib_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
        end
    end

    assign o_req_ready  = req_ready_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_data   = rsp_data_q;
    assign o_rsp_err    = rsp_err_q;
    assign o_cmd_valid  = cmd_valid_q;
    assign o_cmd_data   = cmd_data_q;
    assign o_drv_accept = drv_take;

endmodule

// File: doc/x_host.md
X_HOST -- requirements
Module: x_host

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum wait in cycles for a driver byte before an error response.
REQ-002 i_clk  input  1  clock; all state SHALL change on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req_valid  input  1  host request present.
REQ-005 o_req_ready  output  1  block idle; request accepted when i_req_valid & o_req_ready.
REQ-006 i_req_op  input  2  0 WRITE, 1 READ, 2 SAMPLE, 3 EDGE.
REQ-007 i_req_data  input  32  WRITE payload; ignored for other ops.
REQ-008 o_rsp_valid  output  1  one-cycle completion pulse.
REQ-009 o_rsp_data  output  32  response word; held until the next request.
REQ-010 o_rsp_err  output  1  qualifies o_rsp_valid; 1 = timeout.
REQ-011 o_cmd_valid  output  1  command byte strobe to the driver, one cycle per byte, no backpressure.
REQ-012 o_cmd_data  output  8  command byte: [7:4] nibble payload, [3:0] opcode.
REQ-013 i_drv_valid  input  1  driver return byte valid.
REQ-014 i_drv_data  input  8  driver return byte.
REQ-015 o_drv_accept  output  1  one-cycle accept of the current driver byte.

Function
REQ-016 Opcodes SHALL be LOAD=4'h0, UNLOAD=4'h1, SAMPLE=4'h2, EDGE=4'h3.
REQ-017 States SHALL be IDLE, LOAD, SETTLE, UNLOAD, WAIT, DONE; o_req_ready=1 only in IDLE.
REQ-018 WRITE: 8 consecutive cycles of LOAD bytes, nibbles MSB first ({data[31:28],4'h0} first, {data[3:0],4'h0} last), then DONE.
REQ-019 READ: 4 iterations of UNLOAD byte 8'h01 then WAIT; rsp shifts left 8 and takes i_drv_data on capture, so the first byte lands in [31:24].
REQ-020 In WAIT, on i_drv_valid=1: capture the byte and assert o_drv_accept that same cycle; the next UNLOAD byte SHALL NOT be sent before the following cycle.
REQ-021 SAMPLE: send 8'h02, spend 2 cycles in SETTLE with o_cmd_valid=0, then run the READ sequence.
REQ-022 EDGE: send 8'h03, WAIT for one byte, accept it; rsp = {27'b0, i_drv_data[4:0]}.
REQ-023 WRITE response: o_rsp_data=0, o_rsp_err=0.
REQ-024 DONE: o_rsp_valid=1 for exactly one cycle, then IDLE.
REQ-025 Latency, request accept at cycle 0:
- WRITE: cmd cycles 1-8, rsp_valid cycle 9.
- EDGE with driver byte at cycle k: rsp_valid at k+1.
REQ-026 WAIT timeout counter clears on entering WAIT; at count TIMEOUT with no i_drv_valid -> DONE with o_rsp_err=1, o_rsp_data=0, remaining bytes abandoned.
REQ-027 i_drv_valid outside WAIT SHALL be ignored and never accepted.
REQ-028 i_req_valid while not ready SHALL have no effect; request fields SHALL be registered at acceptance.

Reset
REQ-029 On reset: state IDLE, o_req_ready=1; o_rsp_valid, o_rsp_err, o_cmd_valid, o_drv_accept=0; o_rsp_data, o_cmd_data=0; counters 0.
REQ-030 Reset mid-operation SHALL abort with no response pulse.

Structure
REQ-031 Shared package SHALL hold the driver opcode constants, the request-op enum and the state enum.
REQ-032 No sub-module is required; the FSM, nibble/byte counters and the timeout counter SHALL live in x_host.

Verification
REQ-033 WRITE 32'hDEADBEEF -> cmd bytes D0,E0,A0,D0,B0,E0,E0,F0 on cycles 1-8, rsp_valid cycle 9, data 0, err 0.
REQ-034 READ with driver model returning 12,34,56,78 -> four 8'h01 cmds, four accepts, rsp 32'h12345678.
REQ-035 SAMPLE -> 8'h02, two silent cycles, then READ sequence; rsp equals the model's sampled word.
REQ-036 EDGE with driver byte 8'h1F after 3 cycles -> rsp 32'h0000001F, one accept.
REQ-037 READ with the driver silent -> rsp_valid with err=1 exactly TIMEOUT cycles after the first WAIT entry.
REQ-038 Reset asserted on the 4th LOAD byte -> all outputs 0, no rsp_valid; next WRITE completes normally.
